// File: rtl/sprite_motion_ctrl_pkg.sv
// sprite_motion_ctrl_pkg: register map, field indices, state encoding and clamp helper
package sprite_motion_ctrl_pkg;
    localparam int COORD_W = 16;
    localparam logic [1:0] ADDR_POSITION = 2'd0;
    localparam logic [1:0] ADDR_TARGET = 2'd1;
    localparam logic [1:0] ADDR_CONTROL = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;
    localparam int CTRL_EN = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_STEP_LSB = 8;
    localparam int STAT_BUSY = 0;
    localparam int STAT_ARRIVED = 1;
    typedef enum logic {IDLE, MOVING} state_t;
    function automatic logic [COORD_W-1:0] clamp(input logic [COORD_W-1:0] v, input logic [COORD_W-1:0] m);
        return v > m ? m : v;
    endfunction
endpackage

// File: rtl/sprite_motion_ctrl_if.sv
// sprite_motion_ctrl_if: Avalon-MM slave bus bundle
interface sprite_motion_ctrl_if;
    logic [1:0] address;
    logic chipselect;
    logic write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    modport master(output address, chipselect, write_n, writedata, input readdata);
    modport slave(input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/sprite_motion_ctrl_axis_stepper.sv
// axis_stepper: one axis moves toward its target by at most step, snapping when within reach
module axis_stepper
    import sprite_motion_ctrl_pkg::*;
(
    input  logic [COORD_W-1:0] pos,
    input  logic [COORD_W-1:0] target,
    input  logic [3:0]         step,
    output logic [COORD_W-1:0] next_pos,
    output logic               done
);
    logic signed [COORD_W:0] diff;
    logic [COORD_W:0] mag;
    logic [COORD_W-1:0] step_w;
    always_comb begin
        step_w = COORD_W'(step);
        diff = $signed({1'b0, target}) - $signed({1'b0, pos});
        mag = diff[COORD_W] ? $unsigned(-diff) : $unsigned(diff);
        next_pos = mag <= {1'b0, step_w} ? target : diff[COORD_W] ? pos - step_w : pos + step_w;
        done = next_pos == target;
    end
endmodule

// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl: vsync-paced sprite position sequencer with Avalon-MM registers and arrival irq
module sprite_motion_ctrl
    import sprite_motion_ctrl_pkg::*;
#(
    parameter int X_MAX = 639,
    parameter int Y_MAX = 479,
    parameter int RESET_X = 0,
    parameter int RESET_Y = 0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    sprite_motion_ctrl_if.slave        bus,
    input  logic                       vsync,
    output logic [31:0]                out_port,
    output logic                       irq
);
    logic [COORD_W-1:0] pos_x, pos_y, tgt_x, tgt_y, nxt_x, nxt_y, wr_x, wr_y;
    logic done_x, done_y, enable, irq_en, arrived, wr;
    logic [3:0] step;
    logic sync0, sync1, sync_d, tick;
    state_t state;

    axis_stepper u_x (.pos(pos_x), .target(tgt_x), .step(step), .next_pos(nxt_x), .done(done_x));
    axis_stepper u_y (.pos(pos_y), .target(tgt_y), .step(step), .next_pos(nxt_y), .done(done_y));

    assign wr = bus.chipselect && !bus.write_n;
    assign wr_x = clamp(bus.writedata[15:0], COORD_W'(X_MAX));
    assign wr_y = clamp(bus.writedata[31:16], COORD_W'(Y_MAX));
    assign out_port = {pos_y, pos_x};
    assign irq = arrived & irq_en;

    always_comb begin
        bus.readdata = bus.address == ADDR_POSITION ? {pos_y, pos_x}
                     : bus.address == ADDR_TARGET ? {tgt_y, tgt_x}
                     : bus.address == ADDR_CONTROL ? {20'b0, step, 6'b0, irq_en, enable}
                     : {30'b0, arrived, state == MOVING};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pos_x <= COORD_W'(RESET_X);
            pos_y <= COORD_W'(RESET_Y);
            tgt_x <= COORD_W'(RESET_X);
            tgt_y <= COORD_W'(RESET_Y);
            enable <= 1'b0;
            irq_en <= 1'b0;
            step <= 4'd1;
            arrived <= 1'b0;
            state <= IDLE;
            sync0 <= 1'b0;
            sync1 <= 1'b0;
            sync_d <= 1'b0;
            tick <= 1'b0;
        end else begin
            sync0 <= vsync;
            sync1 <= sync0;
            sync_d <= sync1;
            tick <= sync1 & ~sync_d;
            if (wr && bus.address == ADDR_STATUS && bus.writedata[STAT_ARRIVED])
                arrived <= 1'b0;
            // position/target writes take priority over a coincident frame step
            if (wr && bus.address == ADDR_POSITION) begin
                pos_x <= wr_x;
                pos_y <= wr_y;
                tgt_x <= wr_x;
                tgt_y <= wr_y;
                state <= IDLE;
            end else if (wr && bus.address == ADDR_TARGET) begin
                tgt_x <= wr_x;
                tgt_y <= wr_y;
                if (enable)
                    state <= MOVING;
            end else if (state == MOVING && tick && enable) begin
                pos_x <= nxt_x;
                pos_y <= nxt_y;
                if (done_x && done_y) begin
                    arrived <= 1'b1;
                    state <= IDLE;
                end
            end else if (state == MOVING && !enable) begin
                state <= IDLE;
            end
            if (wr && bus.address == ADDR_CONTROL) begin
                enable <= bus.writedata[CTRL_EN];
                irq_en <= bus.writedata[CTRL_IRQ_EN];
                step <= bus.writedata[CTRL_STEP_LSB +: 4];
                if (!bus.writedata[CTRL_EN])
                    state <= IDLE;
                else if (state == IDLE && {pos_y, pos_x} != {tgt_y, tgt_x})
                    state <= MOVING;
            end
        end
    end
endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// tb_sprite_motion_ctrl: directed self-checking bench for sprite_motion_ctrl
module tb_sprite_motion_ctrl;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic vsync = 1'b0;
    logic [31:0] out_port;
    logic irq;
    logic [31:0] rd;
    int n_checks = 0;
    int n_fail = 0;

    sprite_motion_ctrl_if bus();
    sprite_motion_ctrl dut (.clk(clk), .reset_n(reset_n), .bus(bus), .vsync(vsync), .out_port(out_port), .irq(irq));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        bus.address = a;
        bus.writedata = d;
        bus.chipselect = 1'b1;
        bus.write_n = 1'b0;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        #1;
        bus.address = a;
        bus.chipselect = 1'b1;
        bus.write_n = 1'b1;
        #1;
        d = bus.readdata;
        bus.chipselect = 1'b0;
    endtask

    task automatic vsync_pulse();
        @(posedge clk);
        #1 vsync = 1'b1;
        repeat (3) @(posedge clk);
        #1 vsync = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic test_reset();
        bus.address = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n = 1'b1;
        bus.writedata = 32'h0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge clk);
        bus_read(2'd0, rd); check("reset_position", rd, 32'h0000_0000);
        bus_read(2'd1, rd); check("reset_target", rd, 32'h0000_0000);
        bus_read(2'd2, rd); check("reset_control", rd, 32'h0000_0100);
        bus_read(2'd3, rd); check("reset_status", rd, 32'h0000_0000);
        check("reset_irq", {31'b0, irq}, 32'h0);
        check("reset_out_port", out_port, 32'h0);
    endtask

    task automatic test_move();
        bus_write(2'd2, 32'h0000_0403);
        bus_write(2'd1, 32'h000A_000A);
        bus_read(2'd3, rd); check("move_busy_start", rd, 32'h1);
        vsync_pulse();
        check("move_step1", out_port, 32'h0004_0004);
        bus_read(2'd3, rd); check("move_busy1", rd, 32'h1);
        vsync_pulse();
        check("move_step2", out_port, 32'h0008_0008);
        bus_read(2'd3, rd); check("move_busy2", rd, 32'h1);
        vsync_pulse();
        check("move_step3", out_port, 32'h000A_000A);
        bus_read(2'd3, rd); check("move_arrived", rd, 32'h2);
        check("move_irq", {31'b0, irq}, 32'h1);
        vsync_pulse();
        check("move_hold_after_arrival", out_port, 32'h000A_000A);
    endtask

    task automatic test_clear_and_clamp();
        bus_write(2'd3, 32'h0000_0002);
        bus_read(2'd3, rd); check("clear_status", rd, 32'h0);
        check("clear_irq", {31'b0, irq}, 32'h0);
        bus_write(2'd1, 32'h03E8_02BC);
        bus_read(2'd1, rd); check("clamp_target", rd, 32'h01DF_027F);
        bus_read(2'd3, rd); check("clamp_busy", rd, 32'h1);
    endtask

    task automatic test_write_vs_tick();
        @(posedge clk);
        #1 vsync = 1'b1;
        repeat (2) @(posedge clk);
        bus_write(2'd0, 32'h0005_0005);
        vsync = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("collide_out_port", out_port, 32'h0005_0005);
        bus_read(2'd1, rd); check("collide_target", rd, 32'h0005_0005);
        bus_read(2'd3, rd); check("collide_status", rd, 32'h0);
    endtask

    task automatic test_disable_mid_move();
        bus_write(2'd2, 32'h0000_0203);
        bus_read(2'd3, rd); check("disable_idle_when_at_target", rd, 32'h0);
        bus_write(2'd1, 32'h0014_0014);
        vsync_pulse();
        check("disable_step", out_port, 32'h0007_0007);
        bus_write(2'd2, 32'h0000_0202);
        bus_read(2'd3, rd); check("disable_status", rd, 32'h0);
        vsync_pulse();
        vsync_pulse();
        check("disable_hold", out_port, 32'h0007_0007);
        bus_read(2'd3, rd); check("disable_no_arrival", rd, 32'h0);
    endtask

    task automatic test_step_zero_and_same_target();
        bus_write(2'd2, 32'h0000_0003);
        bus_write(2'd1, 32'h0009_0009);
        vsync_pulse();
        check("step0_hold", out_port, 32'h0007_0007);
        bus_read(2'd3, rd); check("step0_busy", rd, 32'h1);
        bus_write(2'd1, 32'h0007_0007);
        bus_read(2'd3, rd); check("same_target_busy", rd, 32'h1);
        vsync_pulse();
        bus_read(2'd3, rd); check("same_target_arrived", rd, 32'h2);
        check("same_target_irq", {31'b0, irq}, 32'h1);
    endtask

    task automatic test_async_reset();
        bus_write(2'd2, 32'h0000_0403);
        bus_write(2'd1, 32'h0064_0064);
        vsync_pulse();
        check("prereset_step", out_port, 32'h000B_000B);
        check("prereset_irq", {31'b0, irq}, 32'h1);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("async_reset_out_port", out_port, 32'h0);
        check("async_reset_irq", {31'b0, irq}, 32'h0);
        bus_read(2'd3, rd); check("async_reset_status", rd, 32'h0);
        bus_read(2'd2, rd); check("async_reset_control", rd, 32'h0000_0100);
        @(posedge clk);
        #1 reset_n = 1'b1;
        vsync_pulse();
        check("after_reset_idle", out_port, 32'h0);
    endtask

    initial begin
        test_reset();
        test_move();
        test_clear_and_clamp();
        test_write_vs_tick();
        test_disable_mid_move();
        test_step_zero_and_same_target();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sprite_motion_ctrl.md
Name: sprite_motion_ctrl

Overview:
Avalon-MM slave that sequences the 32-bit sprite position word driven to the HDMI pixel pipeline. Software writes a target coordinate and step size. The block moves the live position toward the target by at most STEP pixels per axis once per video frame, synchronised to vsync. It raises an interrupt on arrival. It replaces the bare position PIO, so out_port keeps the same packing and meaning.

Parameters:
X_MAX, 639, largest legal x coordinate (inclusive)
Y_MAX, 479, largest legal y coordinate (inclusive)
RESET_X, 0, x position after reset
RESET_Y, 0, y position after reset

Ports:
clk  in  1  system clock
reset_n  in  1  reset; asynchronous assert, active-low
address  in  2  register select
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  combinational read data, zero wait states
vsync  in  1  video vertical sync, asynchronous to clk, active-high
out_port  out  32  live position {y[15:0], x[15:0]}
irq  out  1  level interrupt: arrived AND irq_en

Behaviour:
- Register map. Write occurs when chipselect && !write_n. Unused readdata bits read 0.
  - 0 POSITION: R/W {y,x}. A write teleports: each axis is clamped to X_MAX/Y_MAX, target := written position, state -> IDLE. It does not set arrived.
  - 1 TARGET: R/W {y,x}, clamped on write. Write sets state -> MOVING if enable=1, else it is latched only.
  - 2 CONTROL: R/W. bit0 enable, bit1 irq_en, bits[11:8] step (4-bit unsigned).
  - 3 STATUS: R. bit0 busy (state==MOVING), bit1 arrived (sticky). Writing 1 to bit1 clears arrived; writes to other bits are ignored.
- Reset values:
  - position={RESET_Y,RESET_X}; target=position
  - enable=0, irq_en=0, step=1, arrived=0
  - state=IDLE; irq=0; sync flops=0
- Frame tick:
  - vsync passes through a 2-flop synchroniser, then a rising-edge detect, giving a 1-cycle tick.
  - The tick asserts on the 3rd clk edge after vsync rises; level and fall produce nothing.
- FSM, states IDLE and MOVING:
  - IDLE -> MOVING on a TARGET write with enable=1, or on a CONTROL write setting enable=1 while position!=target.
  - MOVING, on tick: each axis independently. If |target-pos| <= step then pos := target; else pos moves by +/- step toward target.
  - out_port updates on the clk edge after the tick cycle.
  - After the step, if pos==target: set arrived, state -> IDLE. The step that completes the move and arrived=1 appear in the same cycle.
  - MOVING with enable cleared: state -> IDLE at once. Position holds and arrived is not set.
  - step=0: no movement, remains MOVING (busy stays 1).
  - TARGET write while MOVING: new target takes effect from the next tick. No arrival is flagged for the old target.
  - TARGET write equal to the current position with enable=1: enter MOVING; arrival is flagged at the next tick.
- Simultaneous events:
  - Write to address 0 or 1 in a tick cycle: the write wins and that tick's step is dropped.
  - Status clear in the same cycle as arrival being set: set wins.
- Arithmetic:
  - Coordinates are 16-bit unsigned. Differences use a 17-bit signed intermediate, so there is no wrap.
  - Because both position and target are clamped, a step can never leave [0..MAX].
- irq = arrived & irq_en, registered-free combinational AND of flops.
- Reset mid-move: asynchronously returns everything to the reset values.

Decomposition:
- Shared package holds:
  - register address constants ADDR_POSITION=0, ADDR_TARGET=1, ADDR_CONTROL=2, ADDR_STATUS=3
  - CONTROL/STATUS bit indices
  - the state encoding
  - COORD_W=16
- One natural sub-module, axis_stepper: combinational pos/target/step -> next_pos and done. It is instantiated twice, once for x and once for y.
- The synchroniser/edge detect and the FSM stay in the top level.

Test Plan:
- Reset, then read all 4 registers -> POSITION=0x00000000, CONTROL=0x00000100, STATUS=0, irq=0.
- CONTROL=0x403 (enable, irq_en, step 4), TARGET={y=10,x=10} from {0,0}, then 3 vsync pulses -> out_port steps 0x00040004, 0x00080008, 0x000A000A. busy=1 until the 3rd step; arrived=1 and irq=1 after the 3rd step.
- Write STATUS=0x2 -> arrived=0, irq=0. A TARGET write of {y=1000,x=700} reads back {479,639}.
- Assert a vsync edge so its tick coincides with a POSITION write {5,5} while MOVING -> out_port=0x00050005, no step applied, busy=0.
- Clear enable mid-move with step=2 -> movement stops at the current value. Further vsyncs leave out_port unchanged and arrived stays 0.
- Assert reset_n=0 asynchronously mid-move (no clk edge) -> out_port=0 and irq=0 immediately.
